// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I load or store at a time, checks width and
// alignment, drives a byte-masked data-memory request and returns extended load data.
module lsu #(
  parameter int unsigned MAX_WAIT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_req,
  input  logic        ip_is_store,
  input  logic [2:0]  ip_funct3,
  input  logic [31:0] ip_addr,
  input  logic [31:0] ip_store_data,
  output logic        op_busy,
  output logic        op_done,
  output logic [31:0] op_load_data,
  output logic        op_error,
  output logic        op_timeout,
  output logic [31:0] op_data_addr,
  output logic        op_data_wr,
  output logic [3:0]  op_data_mask,
  output logic [31:0] op_data_to_dmem,
  output logic        op_data_rd,
  input  logic        ip_data_valid,
  input  logic [31:0] ip_data_from_dmem
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic [WaitW-1:0]  wait_q;
  logic              error_q, timeout_q;
  logic [31:0]       load_data_q, addr_q, wdata_q;
  logic [3:0]        mask_q;

  logic              accept, fault, wait_expired, load_wait;
  logic [3:0]        mask_new;
  logic [31:0]       wdata_new, load_ext, byte_sel;
  logic [15:0]       half_sel;

  assign accept       = (state_q == StIdle) && ip_req;
  assign wait_expired = (wait_q == WaitW'(MAX_WAIT_CYCLES));
  assign load_wait    = (state_q == StAccess) && !is_store_q;

  // Illegal width code or misaligned address for the incoming request
  always_comb begin
    fault = 1'b0;
    if (ip_is_store) begin
      if (ip_funct3 > 3'd2) fault = 1'b1;
    end else if (ip_funct3 inside {3'd3, 3'd6, 3'd7}) begin
      fault = 1'b1;
    end
    case (ip_funct3[1:0])
      2'b01:   if (ip_addr[0]) fault = 1'b1;
      2'b10:   if (ip_addr[1:0] != 2'b00) fault = 1'b1;
      default: ;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    mask_new  = 4'b0000;
    wdata_new = ip_store_data;
    case (ip_funct3[1:0])
      2'b00: begin
        mask_new  = 4'b0001 << ip_addr[1:0];
        wdata_new = {4{ip_store_data[7:0]}};
      end
      2'b01: begin
        mask_new  = 4'b0011 << {ip_addr[1], 1'b0};
        wdata_new = {2{ip_store_data[15:0]}};
      end
      2'b10:   mask_new = 4'b1111;
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    byte_sel = ip_data_from_dmem >> {offset_q, 3'b000};
    half_sel = offset_q[1] ? ip_data_from_dmem[31:16] : ip_data_from_dmem[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel[7:0]};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'd0, byte_sel[7:0]};
      3'd5:    load_ext = {16'd0, half_sel};
      default: load_ext = ip_data_from_dmem;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (ip_req) state_d = fault ? StDone : StAccess;
      StAccess: begin
        if (is_store_q || ip_data_valid || wait_expired) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs; memory strobes are gated by reset so an abort suppresses the access
  always_comb begin
    op_busy         = (state_q != StIdle);
    op_done         = (state_q == StDone);
    op_error        = op_done && error_q;
    op_timeout      = op_done && timeout_q;
    op_data_wr      = (state_q == StAccess) && is_store_q && !reset;
    op_data_rd      = (state_q == StAccess) && !is_store_q && !reset;
    op_data_addr    = addr_q;
    op_data_mask    = mask_q;
    op_data_to_dmem = wdata_q;
    op_load_data    = load_data_q;
  end

  // Request latch, wait counter and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      addr_q      <= 32'd0;
      mask_q      <= 4'd0;
      wdata_q     <= 32'd0;
      wait_q      <= '0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      load_data_q <= 32'd0;
    end else if (accept) begin
      is_store_q <= ip_is_store;
      funct3_q   <= ip_funct3;
      offset_q   <= ip_addr[1:0];
      addr_q     <= {ip_addr[31:2], 2'b00};
      mask_q     <= mask_new;
      wdata_q    <= wdata_new;
      wait_q     <= '0;
      error_q    <= fault;
      timeout_q  <= 1'b0;
    end else if (load_wait) begin
      if (ip_data_valid)     load_data_q <= load_ext;
      else if (wait_expired) timeout_q   <= 1'b1;
      else                   wait_q      <= wait_q + WaitW'(1);
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, faults, timeout and reset abort.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ip_req, ip_is_store;
  logic [2:0]  ip_funct3;
  logic [31:0] ip_addr, ip_store_data;
  logic        op_busy, op_done, op_error, op_timeout, op_data_wr, op_data_rd;
  logic [31:0] op_load_data, op_data_addr, op_data_to_dmem;
  logic [3:0]  op_data_mask;
  logic        ip_data_valid;
  logic [31:0] ip_data_from_dmem;

  always #5 clk = ~clk;

  lsu #(.MAX_WAIT_CYCLES(15)) dut (
    .clk               (clk),
    .reset             (reset),
    .ip_req            (ip_req),
    .ip_is_store       (ip_is_store),
    .ip_funct3         (ip_funct3),
    .ip_addr           (ip_addr),
    .ip_store_data     (ip_store_data),
    .op_busy           (op_busy),
    .op_done           (op_done),
    .op_load_data      (op_load_data),
    .op_error          (op_error),
    .op_timeout        (op_timeout),
    .op_data_addr      (op_data_addr),
    .op_data_wr        (op_data_wr),
    .op_data_mask      (op_data_mask),
    .op_data_to_dmem   (op_data_to_dmem),
    .op_data_rd        (op_data_rd),
    .ip_data_valid     (ip_data_valid),
    .ip_data_from_dmem (ip_data_from_dmem)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: answers after valid_delay read cycles; negative means never
  int valid_delay = 0;
  int rd_seen = 0;
  always @(posedge clk) begin
    if (op_data_rd) rd_seen <= rd_seen + 1;
    else            rd_seen <= 0;
  end
  assign ip_data_valid     = op_data_rd && (valid_delay >= 0) && (rd_seen >= valid_delay);
  assign ip_data_from_dmem = 32'h80FF7F01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request (called #1 after an edge); returns once back in IDLE
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int wrs, output int rds,
                        output logic err, output logic tmo, output logic [31:0] w_addr,
                        output logic [3:0] w_mask, output logic [31:0] w_data);
    ip_req = 1'b1; ip_is_store = st; ip_funct3 = f3; ip_addr = a; ip_store_data = d;
    @(posedge clk); #1;
    ip_req = 1'b0;
    lat = 1; wrs = 0; rds = 0; w_addr = '0; w_mask = '0; w_data = '0;
    while (!op_done && lat < 40) begin
      if (op_data_wr) begin
        wrs++; w_addr = op_data_addr; w_mask = op_data_mask; w_data = op_data_to_dmem;
      end
      if (op_data_rd) rds++;
      @(posedge clk); #1;
      lat++;
    end
    err = op_error;
    tmo = op_timeout;
    @(posedge clk); #1;
  endtask

  int          lat, wrs, rds;
  logic        err, tmo;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_mask;

  typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] exp;} ld_vec_t;
  ld_vec_t lds[5];

  initial begin
    reset = 1'b1; ip_req = 1'b0; ip_is_store = 1'b0; ip_funct3 = '0;
    ip_addr = '0; ip_store_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, op_busy}, 32'd0);
    check("rst_done", {31'd0, op_done}, 32'd0);
    check("rst_wr_rd", {30'd0, op_data_wr, op_data_rd}, 32'd0);
    check("rst_addr", op_data_addr, 32'd0);
    check("rst_mask", {28'd0, op_data_mask}, 32'd0);
    check("rst_ldata", op_load_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Stores
    run_op(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
    check("sw_lat", lat, 2);
    check("sw_wrs", wrs, 1);
    check("sw_rds", rds, 0);
    check("sw_addr", w_addr, 32'h104);
    check("sw_mask", {28'd0, w_mask}, 32'hF);
    check("sw_data", w_data, 32'hDEADBEEF);
    check("sw_err", {31'd0, err}, 32'd0);
    check("sw_busy_after", {31'd0, op_busy}, 32'd0);
    check("sw_addr_held", op_data_addr, 32'h104);

    run_op(1'b1, 3'd0, 32'h103, 32'h000000A5, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
    check("sb_mask", {28'd0, w_mask}, 32'h8);
    check("sb_data", w_data, 32'hA5A5A5A5);
    check("sb_addr", w_addr, 32'h100);
    check("sb_wrs", wrs, 1);

    run_op(1'b1, 3'd1, 32'h102, 32'h00001234, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
    check("sh_mask", {28'd0, w_mask}, 32'hC);
    check("sh_data", w_data, 32'h12341234);

    // Loads against word 0x80FF7F01, valid in the first ACCESS cycle
    lds[0] = '{3'd0, 32'h203, 32'hFFFFFF80};
    lds[1] = '{3'd4, 32'h203, 32'h00000080};
    lds[2] = '{3'd1, 32'h202, 32'hFFFF80FF};
    lds[3] = '{3'd5, 32'h200, 32'h00007F01};
    lds[4] = '{3'd2, 32'h200, 32'h80FF7F01};
    valid_delay = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, lds[i].f3, lds[i].a, 32'd0, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
      check($sformatf("ld%0d_data", i), op_load_data, lds[i].exp);
      check($sformatf("ld%0d_lat", i), lat, 2);
      check($sformatf("ld%0d_flags", i), {30'd0, err, tmo}, 32'd0);
      check($sformatf("ld%0d_wrs", i), wrs, 0);
    end

    // Faults: misaligned halfword/word, illegal load and store width codes
    for (int i = 0; i < 4; i++) begin
      logic        st;
      logic [2:0]  f;
      logic [31:0] a;
      st = (i == 3);
      f  = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : (i == 2) ? 3'd3 : 3'd4;
      a  = (i == 0) ? 32'h201 : (i == 1) ? 32'h202 : 32'h200;
      run_op(st, f, a, 32'h5555AAAA, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
      check($sformatf("flt%0d_lat", i), lat, 1);
      check($sformatf("flt%0d_err", i), {31'd0, err}, 32'd1);
      check($sformatf("flt%0d_mem", i), wrs + rds, 0);
    end
    check("flt_ldata_kept", op_load_data, 32'h80FF7F01);

    // Timeout: memory never answers
    valid_delay = -1;
    run_op(1'b0, 3'd0, 32'h200, 32'd0, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
    check("tmo_lat", lat, 17);
    check("tmo_flag", {31'd0, tmo}, 32'd1);
    check("tmo_err", {31'd0, err}, 32'd0);
    check("tmo_rds", rds, 16);
    check("tmo_ldata_kept", op_load_data, 32'h80FF7F01);

    // Answer after three wait cycles
    valid_delay = 3;
    run_op(1'b0, 3'd4, 32'h200, 32'd0, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
    check("dly_lat", lat, 5);
    check("dly_tmo", {31'd0, tmo}, 32'd0);
    check("dly_data", op_load_data, 32'h00000001);
    valid_delay = 0;

    // Reset during the store's ACCESS cycle
    ip_req = 1'b1; ip_is_store = 1'b1; ip_funct3 = 3'd2;
    ip_addr = 32'h300; ip_store_data = 32'h11223344;
    @(posedge clk); #1;
    ip_req = 1'b0;
    check("abort_in_access", {31'd0, op_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_wr_gated", {31'd0, op_data_wr}, 32'd0);
    @(posedge clk); #1;
    check("abort_done", {31'd0, op_done}, 32'd0);
    check("abort_busy", {31'd0, op_busy}, 32'd0);
    check("abort_addr", op_data_addr, 32'd0);
    check("abort_mask", {28'd0, op_data_mask}, 32'd0);
    check("abort_wdata", op_data_to_dmem, 32'd0);
    check("abort_ldata", op_load_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(1'b1, 3'd2, 32'h304, 32'hCAFEF00D, lat, wrs, rds, err, tmo, w_addr, w_mask, w_data);
    check("post_rst_lat", lat, 2);
    check("post_rst_wrs", wrs, 1);
    check("post_rst_data", w_data, 32'hCAFEF00D);
    check("post_rst_addr", w_addr, 32'h304);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit on the processor side of the data-memory port. It accepts one RV32I load or store at a time from the execute stage and checks alignment and width. It then drives the byte-masked data-memory request (address, write, mask, read, data) and waits for the read-valid response. Load data is sign- or zero-extended before completion is signalled back to the pipeline.

## Interface
- MAX_WAIT_CYCLES, 15, maximum ACCESS cycles a load waits for ip_data_valid before flagging a timeout (≥1)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- ip_req  in  1  pipeline request; sampled only while op_busy=0
- ip_is_store  in  1  1=store, 0=load
- ip_funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU = 0/1/2/4/5; SB/SH/SW = 0/1/2)
- ip_addr  in  32  byte address
- ip_store_data  in  32  store source, right-aligned
- op_busy  out  1  high from the cycle after acceptance through the DONE cycle
- op_done  out  1  one-cycle completion pulse
- op_load_data  out  32  extended load result; valid with op_done, held until the next load completes
- op_error  out  1  with op_done: misaligned address or illegal funct3
- op_timeout  out  1  with op_done: load not answered within MAX_WAIT_CYCLES
- op_data_addr  out  32  word-aligned memory address {addr[31:2],2'b00}
- op_data_wr  out  1  memory write strobe
- op_data_mask  out  4  byte enables
- op_data_to_dmem  out  32  lane-replicated store data
- op_data_rd  out  1  memory read request
- ip_data_valid  in  1  read data valid from memory
- ip_data_from_dmem  in  32  read word from memory

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: when ip_req=1, latch is_store, funct3, addr and store_data.
  - Fault check: halfword with addr[0]=1; word with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 ∈ {3..7}.
  - Fault → DONE with op_error=1. No memory access is issued.
  - Otherwise → ACCESS and clear the wait counter.
- ACCESS, store: op_data_wr=1 for exactly this one cycle, then → DONE.
- ACCESS, load: op_data_rd=1 every ACCESS cycle.
  - On ip_data_valid=1: capture the extended data, then → DONE.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT_CYCLES, → DONE with op_timeout=1; op_load_data is unchanged.
- DONE: op_done=1 for one cycle, then → IDLE. ip_req is ignored outside IDLE.
- Mask:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
- Store data:
  - SB: {4{d[7:0]}}
  - SH: {2{d[15:0]}}
  - SW: d
- Load select, from the byte/half lane given by addr[1:0]:
  - LB/LH: sign-extend
  - LBU/LHU: zero-extend
  - LW: whole word
- op_data_wr and op_data_rd are 0 outside ACCESS.
- op_data_addr, op_data_mask and op_data_to_dmem hold their latched values between requests.

## Timing
- Request accepted at edge N (IDLE, ip_req=1).
  - Faulted: op_done in cycle N+1.
  - Store: write strobe in cycle N+1 (memory writes at edge N+2); op_done in cycle N+2.
  - Load with same-cycle valid: op_done in cycle N+2. Each extra wait cycle adds 1.
  - Timeout: op_done in cycle N+1+MAX_WAIT_CYCLES+1.
- Back-to-back: the next request can be accepted in the cycle after DONE (op_busy=0). Throughput is 1 op per 3 cycles minimum.
- Reset: state → IDLE. All outputs are 0 (op_load_data=0, op_data_addr=0, mask=0), as is the wait counter.
  - op_data_wr and op_data_rd are gated by !reset, so reset asserted during ACCESS suppresses the write at that edge.
  - The aborted op produces no op_done.
- Simultaneous fault and timeout cannot occur: faults never enter ACCESS.
- op_error and op_timeout are 0 whenever op_done=0.

## Test plan
- SW addr=0x104 data=0xDEADBEEF → ACCESS cycle: op_data_addr=0x104, mask=4'b1111, wr=1 for exactly 1 cycle; op_done at N+2, op_error=0.
- SB addr=0x103 data=0x000000A5 → mask=4'b1000, op_data_to_dmem=0xA5A5A5A5; then SH addr=0x102 data=0x1234 → mask=4'b1100, data=0x12341234.
- Memory word 0x80FF7F01 at 0x200, valid same cycle:
  - LB 0x203 → 0xFFFFFF80
  - LBU 0x203 → 0x00000080
  - LH 0x202 → 0xFFFF80FF
  - LHU 0x200 → 0x00007F01
  - LW 0x200 → 0x80FF7F01
- LH addr=0x201, LW addr=0x202, and load funct3=3 → op_done at N+1 with op_error=1; op_data_wr/rd never asserted.
- Load with ip_data_valid held 0, MAX_WAIT_CYCLES=15 → op_done at N+17 with op_timeout=1 and op_load_data unchanged. A repeat run with valid asserted after 3 wait cycles → op_done at N+5, timeout=0.
- Store accepted, reset asserted in the ACCESS cycle → op_data_wr stays 0, no op_done, all outputs 0 the next cycle; a new request after reset completes normally.
